// File: rtl/lut_stream_reader_pkg.sv
`default_nettype none
// ============================================================================
// lut_stream_reader_pkg : shared math helpers for the LUT stream reader
// Revision 1.0
// ============================================================================
package lut_stream_reader_pkg;

    // Ceiling log2 for elaboration-time width derivation.
    function automatic int clog2_int(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lut_stream_reader_skid2.sv
`default_nettype none
// ============================================================================
// dbg_skid2 : two-entry output buffer with flush, head word drives the stream
// Revision 1.0
// ============================================================================
module dbg_skid2 #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   level
);

    logic [W-1:0] head;
    logic [W-1:0] tail;
    logic         pop;
    logic         push;

    assign out_valid = (level != 2'd0);
    assign out_data  = head;
    assign pop       = out_valid && out_ready;
    // The producer reserves space before reading, so a full-and-stalled push never occurs.
    assign push      = in_valid && ((level != 2'd2) || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else if (flush) begin
            level <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (level == 2'd0) head <= in_data;
                    else               tail <= in_data;
                    level <= level + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    level <= level - 2'd1;
                end
                2'b11: begin
                    if (level == 2'd1) begin
                        head <= in_data;
                    end else begin
                        head <= tail;
                        tail <= in_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/lut_stream_reader.sv
`default_nettype none
// ============================================================================
// lut_stream_reader : dumps a window of a registered-output LUT as a stream
// Revision 1.0
// ============================================================================
module lut_stream_reader
    import lut_stream_reader_pkg::*;
#(
    parameter  int WIDTH  = 16,
    parameter  int DEPTH  = 256,
    localparam int AWIDTH = clog2_int(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AWIDTH-1:0] base_addr,
    input  logic [AWIDTH:0]   len,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              ram_re,
    output logic [AWIDTH-1:0] ram_addr,
    input  logic [WIDTH-1:0]  ram_dat,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [WIDTH-1:0]  m_data,
    output logic              m_last
);

    localparam int                LEN_W    = AWIDTH + 1;
    localparam logic [LEN_W-1:0]  DEPTH_L  = LEN_W'(DEPTH);
    localparam logic [AWIDTH-1:0] ADDR_MAX = AWIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [AWIDTH-1:0] addr_q;
    logic [AWIDTH-1:0] addr_src;
    logic [LEN_W-1:0]  len_c;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  issued;
    logic [LEN_W-1:0]  xfered;
    logic              pend;
    logic              pend_last;
    logic              done_q;
    logic              issue;
    logic              last_issue;
    logic              last_xfer;
    logic              room;
    logic              pop;
    logic              flush;
    logic              head_last;
    logic [1:0]        level;

    assign len_c     = (len > DEPTH_L) ? DEPTH_L : len;
    assign pop       = m_valid && m_ready;
    assign flush     = abort && (state != IDLE);
    assign last_xfer = pop && (xfered == len_q - 1'b1);
    // Credit: buffered words plus the read in flight, net of this cycle's pop, must stay below 2.
    assign room      = ({1'b0, level} + {2'b00, pend}) < (3'd2 + {2'b00, pop});
    assign addr_src  = (state == IDLE) ? base_addr : addr_q;
    assign ram_addr  = (state == IDLE) ? (start ? base_addr : '0) : addr_q;
    assign ram_re    = issue;
    assign busy      = (state != IDLE);
    assign done      = done_q;
    assign m_last    = m_valid && head_last;

    always_comb begin
        state_nx   = state;
        issue      = 1'b0;
        last_issue = 1'b0;
        case (state)
            IDLE: begin
                if (start && (len_c != '0)) begin
                    issue      = 1'b1;
                    last_issue = (len_c == LEN_W'(1));
                    state_nx   = last_issue ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (room) begin
                    issue      = 1'b1;
                    last_issue = (issued == len_q - 1'b1);
                    if (last_issue) state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (abort || last_xfer) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            issued    <= '0;
            xfered    <= '0;
            pend      <= 1'b0;
            pend_last <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nx;
            pend      <= issue;
            pend_last <= last_issue;
            done_q    <= 1'b0;
            if (pop) xfered <= xfered + 1'b1;
            if (state == IDLE && start) begin
                len_q  <= len_c;
                xfered <= '0;
                issued <= '0;
                if (len_c == '0) done_q <= 1'b1;
            end
            if (issue) begin
                addr_q <= (addr_src == ADDR_MAX) ? '0 : addr_src + 1'b1;
                issued <= ((state == IDLE) ? '0 : issued) + 1'b1;
            end
            if (state == DRAIN && !abort && last_xfer) done_q <= 1'b1;
        end
    end

    dbg_skid2 #(
        .W (WIDTH + 1)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (pend),
        .in_data   ({pend_last, ram_dat}),
        .out_valid (m_valid),
        .out_ready (m_ready),
        .out_data  ({head_last, m_data}),
        .level     (level)
    );

endmodule
`default_nettype wire

// File: tb/tb_lut_stream_reader.sv
`default_nettype none
// ============================================================================
// tb_lut_stream_reader : queue-based reference model with directed and random dumps
// Revision 1.0
// ============================================================================
module tb_lut_stream_reader;

    localparam int WIDTH  = 16;
    localparam int DEPTH  = 8;
    localparam int AWIDTH = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [AWIDTH-1:0] base_addr;
    logic [AWIDTH:0]   len;
    logic              abort;
    logic              busy;
    logic              done;
    logic              ram_re;
    logic [AWIDTH-1:0] ram_addr;
    logic [WIDTH-1:0]  ram_dat;
    logic              m_valid;
    logic              m_ready;
    logic [WIDTH-1:0]  m_data;
    logic              m_last;

    always #5 clk = ~clk;

    lut_stream_reader #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .ram_re    (ram_re),
        .ram_addr  (ram_addr),
        .ram_dat   (ram_dat),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last)
    );

    logic [WIDTH-1:0] lut [DEPTH];
    always_ff @(posedge clk) ram_dat <= ram_re ? lut[ram_addr] : '0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model state and observation logs
    logic [WIDTH:0] exp_q [$];
    bit  model_busy = 0;
    bit  done_due   = 0;
    bit  stall_prev = 0;
    bit  vprev      = 0;
    logic [WIDTH-1:0] stall_d;
    logic stall_l;
    int  cur_base, clip_m, issued_m, xfer_m;
    int  xd [$];
    int  xl [$];
    int  xc [$];
    int  al [$];
    int  done_c [$];
    int  start_c [$];
    int  vrise [$];

    always @(negedge clk) begin
        bit busy_now;
        bit dn;
        logic [WIDTH:0] w;
        int clip;
        if (rst) begin
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_ram_re", ram_re, 0);
            chk("rst_ram_addr", ram_addr, 0);
            chk("rst_m_valid", m_valid, 0);
            chk("rst_m_data", m_data, 0);
            chk("rst_m_last", m_last, 0);
            exp_q.delete();
            model_busy = 0; done_due = 0; stall_prev = 0; vprev = 0;
        end else begin
            busy_now = model_busy;
            dn = 0;
            chk("busy", busy, busy_now);
            chk("done", done, done_due);
            if (done) done_c.push_back(cyc);
            if (!busy_now) chk("valid_when_idle", m_valid, 0);
            if (stall_prev) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, stall_d);
                chk("hold_last", m_last, stall_l);
            end
            if (m_valid && !vprev) vrise.push_back(cyc);
            vprev = m_valid;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_word", m_data, 32'hDEAD);
                end else begin
                    w = exp_q.pop_front();
                    chk("word_data", m_data, w[WIDTH-1:0]);
                    chk("word_last", m_last, w[WIDTH]);
                    xd.push_back(m_data); xl.push_back(m_last); xc.push_back(cyc);
                    xfer_m++;
                    if (w[WIDTH] && !abort) begin
                        dn = 1;
                        model_busy = 0;
                    end
                end
            end
            if (!busy_now && start) begin
                clip = (int'(len) > DEPTH) ? DEPTH : int'(len);
                start_c.push_back(cyc);
                cur_base = base_addr; clip_m = clip; issued_m = 0; xfer_m = 0;
                if (clip == 0) dn = 1;
                else begin
                    for (int k = 0; k < clip; k++)
                        exp_q.push_back({(k == clip - 1), lut[(cur_base + k) % DEPTH]});
                    model_busy = 1;
                end
            end
            if (ram_re) begin
                al.push_back(ram_addr);
                chk("read_allowed", (busy_now || start) ? 1 : 0, 1);
                chk("read_addr", ram_addr, (cur_base + issued_m) % DEPTH);
                chk("read_credit", ((issued_m - xfer_m) < 2) ? 1 : 0, 1);
                chk("read_count", (issued_m < clip_m) ? 1 : 0, 1);
                issued_m++;
            end
            if (busy_now && abort) begin
                exp_q.delete();
                model_busy = 0;
                dn = 0;
            end
            stall_prev = m_valid && !m_ready && !(busy_now && abort);
            stall_d = m_data;
            stall_l = m_last;
            done_due = dn;
        end
    end

    int rmode = 0;
    initial begin
        int ph;
        ph = 0;
        m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rmode)
                0: m_ready = 1'b1;
                1: begin m_ready = (ph == 0) || (ph == 3); ph = (ph + 1) % 4; end
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_start(input int b, input int l);
        tick();
        start = 1'b1; base_addr = AWIDTH'(b); len = (AWIDTH+1)'(l);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        tick();
        while ((model_busy || done_due || busy) && n < 300) begin tick(); n++; end
        chk("idle_timeout", (n < 300) ? 1 : 0, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int mark, amark, dmark, vmark, nw;
        for (int i = 0; i < DEPTH; i++) lut[i] = WIDTH'(i + 16'h10);
        rst = 1'b1; start = 1'b0; abort = 1'b0; base_addr = '0; len = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Full-depth dump at full rate
        mark = xd.size(); dmark = done_c.size(); vmark = vrise.size();
        do_start(0, 8);
        wait_idle();
        chk("a_count", xd.size() - mark, 8);
        for (int k = 0; k < 8; k++) begin
            chk("a_word", xd[mark + k], 16'h10 + k);
            chk("a_last", xl[mark + k], (k == 7) ? 1 : 0);
            chk("a_cycle", xc[mark + k] - xc[mark], k);
        end
        chk("a_first_valid", vrise[vmark] - start_c[start_c.size() - 1], 2);
        chk("a_done", done_c[dmark] - xc[mark + 7], 1);

        // Wrapping window
        mark = xd.size(); amark = al.size();
        do_start(6, 4);
        wait_idle();
        chk("b_count", xd.size() - mark, 4);
        chk("b_addr0", al[amark], 6);
        chk("b_addr1", al[amark + 1], 7);
        chk("b_addr2", al[amark + 2], 0);
        chk("b_addr3", al[amark + 3], 1);
        chk("b_word0", xd[mark], 16'h16);
        chk("b_word2", xd[mark + 2], 16'h10);
        chk("b_word3", xd[mark + 3], 16'h11);

        // Backpressure pattern 1,0,0,1
        rmode = 1;
        mark = xd.size();
        do_start(2, 3);
        wait_idle();
        chk("c_count", xd.size() - mark, 3);
        chk("c_word0", xd[mark], 16'h12);
        chk("c_word2", xd[mark + 2], 16'h14);
        rmode = 0;

        // Zero length and clipped length
        mark = xd.size(); dmark = done_c.size(); vmark = vrise.size();
        do_start(5, 0);
        wait_idle();
        chk("d_zero_done", done_c.size() - dmark, 1);
        chk("d_zero_done_cycle", done_c[dmark] - start_c[start_c.size() - 1], 1);
        chk("d_zero_words", xd.size() - mark, 0);
        chk("d_zero_valid", vrise.size() - vmark, 0);
        do_start(3, 12);
        wait_idle();
        chk("d_clip_count", xd.size() - mark, 8);
        chk("d_clip_lastword", xd[mark + 7], 16'h12);

        // Abort two cycles after first transfer
        mark = xd.size(); dmark = done_c.size();
        do_start(0, 8);
        nw = 0;
        while (xd.size() == mark && nw < 50) begin tick(); nw++; end
        chk("e_first_xfer", (nw < 50) ? 1 : 0, 1);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("e_valid_after_abort", m_valid, 0);
        repeat (4) tick();
        chk("e_no_done", done_c.size() - dmark, 0);
        chk("e_busy", busy, 0);
        mark = xd.size();
        do_start(0, 2);
        wait_idle();
        chk("e_count", xd.size() - mark, 2);
        chk("e_word0", xd[mark], 16'h10);
        chk("e_word1", xd[mark + 1], 16'h11);

        // Reset mid-dump, then a start while busy
        do_start(0, 8);
        repeat (3) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        mark = xd.size();
        do_start(2, 5);
        repeat (2) tick();
        start = 1'b1; base_addr = '0; len = 4'd1;
        tick();
        start = 1'b0;
        wait_idle();
        chk("f_count", xd.size() - mark, 5);
        for (int k = 0; k < 5; k++) chk("f_word", xd[mark + k], 16'h12 + k);

        // Randomized dumps with random contents, backpressure and aborts
        for (int i = 0; i < DEPTH; i++) lut[i] = WIDTH'($urandom);
        rmode = 2;
        for (int t = 0; t < 40; t++) begin
            do_start($urandom_range(0, DEPTH - 1), $urandom_range(0, 12));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 6)) tick();
                abort = 1'b1;
                tick();
                abort = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                tick();
                start = 1'b1; base_addr = AWIDTH'($urandom); len = 4'($urandom_range(1, 8));
                tick();
                start = 1'b0;
            end
            wait_idle();
        end

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
